// File: rtl/edc_scrubber.sv
// Background ECC scrubber: walks the 32b+8b word memory in host-idle slots, repairs single-bit
// errors by write-back and logs uncorrectable ones. Define EDC_SCRUB_IRQ_EN for i_irq_clr/o_irq.

module edc_scrubber #(
  parameter int ADDR_W = 10,
  parameter int IVL_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scrub_en,
  input  logic [IVL_W-1:0]  i_interval,
  input  logic              i_host_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [7:0]        o_mem_wecc,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  input  logic [7:0]        i_mem_recc,
  output logic [15:0]       o_corr_cnt,
  output logic              o_uncorr,
  output logic [ADDR_W-1:0] o_uncorr_addr,
  output logic              o_pass_done
`ifdef EDC_SCRUB_IRQ_EN
  ,
  input  logic              i_irq_clr,
  output logic              o_irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_NEXT
  } state_t;

  // Hsiao-style columns: distinct weight-3 codes, so any double error yields an even-weight syndrome
  localparam logic [31:0][7:0] H_COLS = {
    8'h62, 8'h61, 8'h58, 8'h54, 8'h52, 8'h51, 8'h4C, 8'h4A,
    8'h49, 8'h46, 8'h45, 8'h43, 8'h38, 8'h34, 8'h32, 8'h31,
    8'h2C, 8'h2A, 8'h29, 8'h26, 8'h25, 8'h23, 8'h1C, 8'h1A,
    8'h19, 8'h16, 8'h15, 8'h13, 8'h0E, 8'h0D, 8'h0B, 8'h07
  };

  function automatic logic [7:0] edc_generator(input logic [31:0] data,
                                               input logic [7:0]  ecc,
                                               input logic        write_enabled);
    logic [7:0] parity;
    parity = '0;
    for (int k = 0; k < 32; k++) begin
      if (data[k]) parity = parity ^ H_COLS[k];
    end
    return write_enabled ? parity : (parity ^ ecc);
  endfunction

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   ptr;
  logic [IVL_W-1:0]    ivl_cnt;
  logic [31:0]         data_q;
  logic [7:0]          recc_q;
  logic                req_hold;
  logic [15:0]         corr_cnt;
  logic                uncorr;
  logic [ADDR_W-1:0]   uncorr_addr;
  logic [7:0]          gen_out;
  logic [31:0]         col_match;
  logic                single_err;
  logic                correctable;
  logic                uncorrectable;
  logic                corr_inc;

  // One generator serves both roles: syndrome while checking, fresh check bits while writing back
  assign gen_out = edc_generator(data_q, recc_q, state == S_WRITE);

  always_comb begin
    col_match = '0;
    for (int k = 0; k < 32; k++) col_match[k] = (gen_out == H_COLS[k]);
  end

  assign single_err    = (|col_match) || $onehot(gen_out);
  assign correctable   = (state == S_CHECK) && (gen_out != 8'h00) && single_err;
  assign uncorrectable = (state == S_CHECK) && (gen_out != 8'h00) && !single_err;
  assign corr_inc      = correctable && (corr_cnt != 16'hFFFF);

  assign o_mem_addr    = ptr;
  assign o_mem_wdata   = (state == S_WRITE) ? data_q : '0;
  assign o_mem_wecc    = (state == S_WRITE) ? gen_out : '0;
  assign o_corr_cnt    = corr_cnt;
  assign o_uncorr      = uncorr;
  assign o_uncorr_addr = uncorr_addr;
  assign o_pass_done   = (state == S_NEXT) && (ptr == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // A request may only start in a host-idle cycle; once started it is held until ack
  always_comb begin
    next_state = state;
    o_mem_req  = 1'b0;
    o_mem_we   = 1'b0;
    case (state)
      S_IDLE:  if (i_scrub_en) next_state = S_WAIT;
      S_WAIT:  if ((ivl_cnt == '0) && !i_host_busy) next_state = S_READ;
      S_READ: begin
        o_mem_req = req_hold || !i_host_busy;
        if (o_mem_req && i_mem_ack) next_state = S_CHECK;
      end
      S_CHECK: begin
        if (correctable) next_state = S_WRITE;
        else             next_state = S_NEXT;
      end
      S_WRITE: begin
        o_mem_req = req_hold || !i_host_busy;
        o_mem_we  = 1'b1;
        if (o_mem_req && i_mem_ack) next_state = S_NEXT;
      end
      S_NEXT:  next_state = i_scrub_en ? S_WAIT : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr         <= '0;
      ivl_cnt     <= '0;
      data_q      <= '0;
      recc_q      <= '0;
      req_hold    <= 1'b0;
      corr_cnt    <= '0;
      uncorr      <= 1'b0;
      uncorr_addr <= '0;
    end else begin
      req_hold <= o_mem_req && !i_mem_ack;
      case (state)
        S_IDLE:  if (i_scrub_en) ivl_cnt <= i_interval;
        S_WAIT:  if (ivl_cnt != '0) ivl_cnt <= ivl_cnt - 1'b1;
        S_READ: begin
          if (o_mem_req && i_mem_ack) begin
            data_q <= i_mem_rdata;
            recc_q <= i_mem_recc;
          end
        end
        S_CHECK: begin
          if (correctable) begin
            data_q <= data_q ^ col_match;
            if (corr_inc) corr_cnt <= corr_cnt + 16'd1;
          end else if (uncorrectable) begin
            uncorr <= 1'b1;
            if (!uncorr) uncorr_addr <= ptr;
          end
        end
        S_NEXT: begin
          ptr     <= ptr + 1'b1;
          ivl_cnt <= i_interval;
        end
        default: ;
      endcase
    end
  end

`ifdef EDC_SCRUB_IRQ_EN
  // A fresh event wins over a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      o_irq <= 1'b0;
    else if (corr_inc || uncorrectable) o_irq <= 1'b1;
    else if (i_irq_clr)                o_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_edc_scrubber.sv
// Directed self-checking bench for edc_scrubber with a 16-word memory model and programmable ack latency.

module tb_edc_scrubber;

  localparam int ADDR_W = 4;
  localparam int IVL_W  = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scrub_en = 1'b0;
  logic [IVL_W-1:0]  interval = '0;
  logic              host_busy = 1'b0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [7:0]        mem_wecc;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [7:0]        mem_recc;
  logic [15:0]       corr_cnt;
  logic              uncorr;
  logic [ADDR_W-1:0] uncorr_addr;
  logic              pass_done;

  logic [31:0]       mem_data [DEPTH];
  logic [7:0]        mem_ecc  [DEPTH];
  int                ack_lat = 0;
  int                req_age = 0;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                read_cnt = 0;
  int                write_cnt = 0;
  int                pass_cnt = 0;
  int                pass_reads = 0;
  int                pass_writes = 0;
  int                last_read_cyc = 0;
  int                read_gap = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       last_wdata = '0;
  logic [7:0]        last_wecc = '0;

  edc_scrubber #(.ADDR_W(ADDR_W), .IVL_W(IVL_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_scrub_en    (scrub_en),
    .i_interval    (interval),
    .i_host_busy   (host_busy),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .o_mem_wecc    (mem_wecc),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .i_mem_recc    (mem_recc),
    .o_corr_cnt    (corr_cnt),
    .o_uncorr      (uncorr),
    .o_uncorr_addr (uncorr_addr),
    .o_pass_done   (pass_done)
  );

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (req_age >= ack_lat);
  assign mem_rdata = mem_data[mem_addr];
  assign mem_recc  = mem_ecc[mem_addr];

  always @(posedge clk) begin
    if (!mem_req || mem_ack) req_age <= 0;
    else                     req_age <= req_age + 1;
  end

  // Memory model and access log, updated mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        write_cnt          = write_cnt + 1;
        last_wr_addr       = mem_addr;
        last_wdata         = mem_wdata;
        last_wecc          = mem_wecc;
        mem_data[mem_addr] = mem_wdata;
        mem_ecc[mem_addr]  = mem_wecc;
      end else begin
        read_cnt      = read_cnt + 1;
        read_gap      = cyc - last_read_cyc;
        last_read_cyc = cyc;
      end
    end
    if (pass_done) begin
      pass_cnt    = pass_cnt + 1;
      pass_reads  = read_cnt;
      pass_writes = write_cnt;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Column k of H = k-th 8-bit value of weight 3 in ascending order
  function automatic logic [7:0] col_of(input int k);
    int n = 0;
    for (int v = 1; v < 256; v++) begin
      if ($countones(v[7:0]) == 3) begin
        if (n == k) return v[7:0];
        n = n + 1;
      end
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] ecc_of(input logic [31:0] d);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 32; k++) if (d[k]) p = p ^ col_of(k);
    return p;
  endfunction

  function automatic logic [31:0] orig(input int a);
    return 32'hA5A5_0000 + 32'(a);
  endfunction

  task automatic init_clean();
    for (int a = 0; a < DEPTH; a++) begin
      mem_data[a] = orig(a);
      mem_ecc[a]  = ecc_of(orig(a));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; scrub_en = 1'b0; host_busy = 1'b0; interval = '0; ack_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    read_cnt = 0; write_cnt = 0; pass_cnt = 0; pass_reads = 0; pass_writes = 0; read_gap = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_pass(input int target, output logic ok);
    int i = 0;
    ok = 1'b0;
    scrub_en = 1'b1;
    while (i < 2000 && !ok) begin
      @(posedge clk);
      if (pass_cnt >= target) ok = 1'b1;
      i = i + 1;
    end
    #1 scrub_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, pass_done, uncorr} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b, expected 0000", {mem_req, mem_we, pass_done, uncorr}); end
    checks++; if (mem_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0h, expected 0", mem_addr); end
    checks++; if ({mem_wdata, mem_wecc} !== 40'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %0h, expected 0", {mem_wdata, mem_wecc}); end
    checks++; if (corr_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_corr_cnt: got %0h, expected 0", corr_cnt); end
    checks++; if (uncorr_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_uncorr_addr: got %0h, expected 0", uncorr_addr); end
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req: got %b, expected 0", mem_req); end
  endtask

  task automatic test_clean_pass();
    logic ok;
    do_reset();
    init_clean();
    run_pass(1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL clean_pass_timeout: got %b, expected 1", ok); end
    checks++; if (pass_reads !== 16) begin errors++; $display("[TB] FAIL clean_reads: got %0d, expected 16", pass_reads); end
    checks++; if (write_cnt !== 0) begin errors++; $display("[TB] FAIL clean_writes: got %0d, expected 0", write_cnt); end
    checks++; if (pass_cnt !== 1) begin errors++; $display("[TB] FAIL clean_pass_pulses: got %0d, expected 1", pass_cnt); end
    checks++; if (corr_cnt !== 16'd0) begin errors++; $display("[TB] FAIL clean_corr_cnt: got %0d, expected 0", corr_cnt); end
    checks++; if (read_gap !== 4) begin errors++; $display("[TB] FAIL clean_latency: got %0d, expected 4", read_gap); end
    checks++; if (uncorr !== 1'b0) begin errors++; $display("[TB] FAIL clean_uncorr: got %b, expected 0", uncorr); end
  endtask

  task automatic test_data_bit();
    logic ok;
    do_reset();
    init_clean();
    mem_data[5] = mem_data[5] ^ 32'h8000_0000;
    run_pass(1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL data_pass_timeout: got %b, expected 1", ok); end
    checks++; if (pass_writes !== 1) begin errors++; $display("[TB] FAIL data_writes: got %0d, expected 1", pass_writes); end
    checks++; if (last_wr_addr !== 4'd5) begin errors++; $display("[TB] FAIL data_wr_addr: got %0d, expected 5", last_wr_addr); end
    checks++; if (last_wdata !== 32'hA5A5_0005) begin errors++; $display("[TB] FAIL data_wdata: got %h, expected a5a50005", last_wdata); end
    checks++; if (last_wecc !== ecc_of(32'hA5A5_0005)) begin errors++; $display("[TB] FAIL data_wecc: got %h, expected %h", last_wecc, ecc_of(32'hA5A5_0005)); end
    checks++; if (corr_cnt !== 16'd1) begin errors++; $display("[TB] FAIL data_corr_cnt: got %0d, expected 1", corr_cnt); end
    run_pass(2, ok);
    checks++; if ({ok, write_cnt[7:0]} !== {1'b1, 8'd1}) begin errors++; $display("[TB] FAIL data_reread: got ok=%b writes=%0d, expected ok=1 writes=1", ok, write_cnt); end
    checks++; if (corr_cnt !== 16'd1) begin errors++; $display("[TB] FAIL data_reread_cnt: got %0d, expected 1", corr_cnt); end
  endtask

  task automatic test_check_bit();
    logic ok;
    do_reset();
    init_clean();
    mem_ecc[3] = mem_ecc[3] ^ 8'h04;
    run_pass(1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL chk_pass_timeout: got %b, expected 1", ok); end
    checks++; if (pass_writes !== 1) begin errors++; $display("[TB] FAIL chk_writes: got %0d, expected 1", pass_writes); end
    checks++; if (last_wr_addr !== 4'd3) begin errors++; $display("[TB] FAIL chk_wr_addr: got %0d, expected 3", last_wr_addr); end
    checks++; if (last_wdata !== 32'hA5A5_0003) begin errors++; $display("[TB] FAIL chk_wdata: got %h, expected a5a50003", last_wdata); end
    checks++; if (last_wecc !== ecc_of(32'hA5A5_0003)) begin errors++; $display("[TB] FAIL chk_wecc: got %h, expected %h", last_wecc, ecc_of(32'hA5A5_0003)); end
    checks++; if (corr_cnt !== 16'd1) begin errors++; $display("[TB] FAIL chk_corr_cnt: got %0d, expected 1", corr_cnt); end
  endtask

  task automatic test_uncorr();
    logic ok;
    do_reset();
    init_clean();
    mem_data[7] = mem_data[7] ^ 32'h3;
    mem_data[9] = mem_data[9] ^ 32'h3;
    run_pass(1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL unc_pass_timeout: got %b, expected 1", ok); end
    checks++; if (write_cnt !== 0) begin errors++; $display("[TB] FAIL unc_writes: got %0d, expected 0", write_cnt); end
    checks++; if (uncorr !== 1'b1) begin errors++; $display("[TB] FAIL unc_flag: got %b, expected 1", uncorr); end
    checks++; if (uncorr_addr !== 4'd7) begin errors++; $display("[TB] FAIL unc_addr: got %0d, expected 7", uncorr_addr); end
    checks++; if (corr_cnt !== 16'd0) begin errors++; $display("[TB] FAIL unc_corr_cnt: got %0d, expected 0", corr_cnt); end
  endtask

  task automatic test_host_busy();
    logic req_seen = 1'b0;
    do_reset();
    init_clean();
    ack_lat = 2;
    host_busy = 1'b1;
    scrub_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (mem_req) req_seen = 1'b1;
    end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_req: got %b, expected 0", req_seen); end
    @(posedge clk); #1 host_busy = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL busy_drop_cycle: got %b, expected 0", mem_req); end
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("[TB] FAIL busy_req_issue: got %b, expected 1_0_0000", {mem_req, mem_we, mem_addr}); end
    @(posedge clk); #1 host_busy = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, mem_ack} !== 2'b10) begin errors++; $display("[TB] FAIL busy_req_hold: got %b, expected 10", {mem_req, mem_ack}); end
    @(negedge clk);
    checks++; if ({mem_req, mem_ack} !== 2'b11) begin errors++; $display("[TB] FAIL busy_req_ack: got %b, expected 11", {mem_req, mem_ack}); end
    @(posedge clk); #1;
    checks++; if (read_cnt !== 1) begin errors++; $display("[TB] FAIL busy_read_cnt: got %0d, expected 1", read_cnt); end
    scrub_en = 1'b0;
    host_busy = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_interval();
    int i = 0;
    do_reset();
    init_clean();
    interval = 16'd3;
    scrub_en = 1'b1;
    while (i < 200 && read_cnt < 3) begin
      @(posedge clk);
      i = i + 1;
    end
    checks++; if ({read_cnt >= 3, read_gap[7:0]} !== {1'b1, 8'd7}) begin errors++; $display("[TB] FAIL interval_gap: got reads=%0d gap=%0d, expected reads>=3 gap=7", read_cnt, read_gap); end
    #1 scrub_en = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic test_scrub_drop();
    logic got = 1'b0;
    int i = 0;
    do_reset();
    init_clean();
    mem_data[0] = mem_data[0] ^ 32'h10;
    ack_lat = 3;
    scrub_en = 1'b1;
    while (i < 200 && !got) begin
      @(negedge clk);
      if (mem_req && mem_we) got = 1'b1;
      i = i + 1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL drop_write_seen: got %b, expected 1", got); end
    @(posedge clk); #1 scrub_en = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (write_cnt !== 1) begin errors++; $display("[TB] FAIL drop_write_done: got %0d, expected 1", write_cnt); end
    checks++; if (last_wdata !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL drop_wdata: got %h, expected a5a50000", last_wdata); end
    checks++; if (read_cnt !== 1) begin errors++; $display("[TB] FAIL drop_parked: got %0d, expected 1", read_cnt); end
    checks++; if ({mem_req, mem_addr} !== {1'b0, 4'd1}) begin errors++; $display("[TB] FAIL drop_ptr_kept: got %b, expected 0_0001", {mem_req, mem_addr}); end
    checks++; if (corr_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_corr_cnt: got %0d, expected 1", corr_cnt); end
    scrub_en = 1'b1;
    got = 1'b0;
    i = 0;
    while (i < 200 && !got) begin
      @(negedge clk);
      if (mem_req && !mem_we) got = 1'b1;
      i = i + 1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL rst_read_seen: got %b, expected 1", got); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, mem_addr} !== 6'd0) begin errors++; $display("[TB] FAIL rst_async_req: got %b, expected 000000", {mem_req, mem_we, mem_addr}); end
    checks++; if ({corr_cnt, uncorr} !== 17'd0) begin errors++; $display("[TB] FAIL rst_async_status: got %0h, expected 0", {corr_cnt, uncorr}); end
    scrub_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_data_bit();
    test_check_bit();
    test_uncorr();
    test_host_busy();
    test_interval();
    test_scrub_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
